// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: op3 access codes, FSM states, access sizes.
// Latency: none. This is a package with no logic.
// Backpressure: not applicable.
package mem_responder_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic  valid;
        logic  store;
        logic  sext;
        size_e size;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [5:0] op3);
        op_dec_t d;
        d       = '0;
        d.size  = WORD;
        d.valid = 1'b1;
        case (op3)
            OP_LD:   d.size = WORD;
            OP_LDUB: d.size = BYTE;
            OP_LDUH: d.size = HALF;
            OP_LDSB: begin d.size = BYTE; d.sext = 1'b1; end
            OP_LDSH: begin d.size = HALF; d.sext = 1'b1; end
            OP_ST:   begin d.size = WORD; d.store = 1'b1; end
            OP_STB:  begin d.size = BYTE; d.store = 1'b1; end
            OP_STH:  begin d.size = HALF; d.store = 1'b1; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Unrecognised opcodes never fault; they complete as no-ops.
    function automatic logic is_misaligned(input op_dec_t d, input logic [1:0] a);
        return d.valid && (((d.size == HALF) && a[0]) ||
                           ((d.size == WORD) && (a != 2'b00)));
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide storage with a four-lane big-endian window at base_addr; lane 0 is bits 31:24.
// Latency: read is combinational, writes land on the rising clock edge.
// Backpressure: none, always accepts a write.
module byte_ram #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        wr_en,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base_addr + ADDR_W'(k);
        end
    end

    assign rd_data = {mem[lane_addr[0]], mem[lane_addr[1]],
                      mem[lane_addr[2]], mem[lane_addr[3]]};

    // wr_en[3] selects lane 0, matching the bit order of wr_data.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[3-k]) begin
                mem[lane_addr[k]] <= wr_data[31-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// SPARC-style load/store responder: captures a request, waits LATENCY+1 cycles, then raises MFC.
// Latency: LATENCY+1 cycles from capture edge to MFC; misaligned accesses complete at the capture edge.
// Backpressure: initiator holds RAM_enable until MFC; dropping it before completion aborts the access.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        Misaligned
);

    localparam logic [3:0] LAST_CNT = 4'(LATENCY);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       dout_q, dout_d;
    logic              mfc_q, mfc_d;
    logic              mis_q, mis_d;

    op_dec_t     cur_dec;
    op_dec_t     req_dec;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [3:0]  lane_en;
    logic [3:0]  wr_en;
    logic [31:0] load_val;
    logic        finish;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^Address[31:ADDR_W];

    assign cur_dec = decode_op(op_q);
    assign req_dec = decode_op(RAM_OpCode);
    assign finish  = (state_q == BUSY) && RAM_enable && (cnt_q == LAST_CNT);

    byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (Clk),
        .base_addr (addr_q),
        .wr_en     (wr_en),
        .wr_data   (wr_word),
        .rd_data   (rd_word)
    );

    // Narrow accesses sit at the top of the window since the addressed byte is lane 0.
    always_comb begin
        wr_word  = data_q;
        lane_en  = 4'b1111;
        load_val = rd_word;
        case (cur_dec.size)
            BYTE: begin
                wr_word  = {data_q[7:0], 24'h0};
                lane_en  = 4'b1000;
                load_val = cur_dec.sext ? {{24{rd_word[31]}}, rd_word[31:24]}
                                        : {24'h0, rd_word[31:24]};
            end
            HALF: begin
                wr_word  = {data_q[15:0], 16'h0};
                lane_en  = 4'b1100;
                load_val = cur_dec.sext ? {{16{rd_word[31]}}, rd_word[31:16]}
                                        : {16'h0, rd_word[31:16]};
            end
            default: begin
                wr_word  = data_q;
                lane_en  = 4'b1111;
                load_val = rd_word;
            end
        endcase
        // A reset on the completion edge must also cancel the write.
        wr_en = (finish && cur_dec.valid && cur_dec.store && Clr) ? lane_en : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (RAM_enable) begin
                    op_d   = RAM_OpCode;
                    addr_d = Address[ADDR_W-1:0];
                    data_d = DataIn;
                    cnt_d  = 4'd0;
                    if (is_misaligned(req_dec, Address[1:0])) begin
                        state_d = DONE;
                        mfc_d   = 1'b1;
                        mis_d   = 1'b1;
                        dout_d  = 32'h0;
                    end else begin
                        state_d = BUSY;
                        mis_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (!RAM_enable) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        mfc_d   = 1'b1;
                        mis_d   = 1'b0;
                        dout_d  = (cur_dec.valid && !cur_dec.store) ? load_val : 32'h0;
                    end
                end
            end
            DONE: begin
                if (!RAM_enable) begin
                    state_d = IDLE;
                    mfc_d   = 1'b0;
                    mis_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                mfc_d   = 1'b0;
                mis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            dout_q  <= 32'h0;
            mfc_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            mis_q   <= mis_d;
        end
    end

    assign DataOut    = dout_q;
    assign MFC        = mfc_q;
    assign Misaligned = mis_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, abort/reset/hold sequences,
// then randomized accesses against a byte-array reference model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int ADDR_W  = 9;
    localparam int LATENCY = 2;
    localparam int MEMSZ   = 1 << ADDR_W;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Misaligned;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .Misaligned (Misaligned)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;
    logic [7:0] ref_mem [MEMSZ];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: big-endian byte array, values computed arithmetically.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] r, output logic m);
        int b;
        int v;
        b = int'(a % 32'(MEMSZ));
        r = 32'h0;
        m = 1'b0;
        case (op)
            OP_LD:   if (b % 4 != 0) m = 1'b1;
                     else r = {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
            OP_LDUB: r = 32'(int'(ref_mem[b]));
            OP_LDSB: begin
                v = int'(ref_mem[b]);
                if (v >= 128) v -= 256;
                r = 32'(v);
            end
            OP_LDUH: if (b % 2 != 0) m = 1'b1;
                     else r = 32'(int'(ref_mem[b]) * 256 + int'(ref_mem[b+1]));
            OP_LDSH: if (b % 2 != 0) m = 1'b1;
                     else begin
                         v = int'(ref_mem[b]) * 256 + int'(ref_mem[b+1]);
                         if (v >= 32768) v -= 65536;
                         r = 32'(v);
                     end
            OP_ST:   if (b % 4 != 0) m = 1'b1;
                     else for (int k = 0; k < 4; k++) ref_mem[b+k] = 8'(d >> (24 - 8*k));
            OP_STB:  ref_mem[b] = d[7:0];
            OP_STH:  if (b % 2 != 0) m = 1'b1;
                     else begin ref_mem[b] = d[15:8]; ref_mem[b+1] = d[7:0]; end
            default: ;
        endcase
    endfunction

    // Issue one request, scramble inputs after capture, wait for MFC, hold, release.
    task automatic run_access(input string name, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] d, input int hold,
                              output logic [31:0] dout, output logic mis, output int lat);
        logic held_ok;
        RAM_enable = 1'b1;
        RAM_OpCode = op;
        Address    = a;
        DataIn     = d;
        lat  = -1;
        dout = 32'hx;
        mis  = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(posedge Clk); #1;
            if (n == 0) begin
                RAM_OpCode = 6'($urandom);
                Address    = $urandom;
                DataIn     = $urandom;
            end
            if (MFC) begin
                lat = n;
                break;
            end
        end
        if (lat >= 0) begin
            dout = DataOut;
            mis  = Misaligned;
            held_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge Clk); #1;
                if (!MFC || DataOut !== dout) held_ok = 1'b0;
            end
            if (hold > 0) check({name, "_hold"}, 32'(held_ok), 32'd1);
        end
        RAM_enable = 1'b0;
        @(posedge Clk); #1;
        check({name, "_release"}, {31'h0, MFC}, 32'h0);
    endtask

    task automatic apply(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] exp_dout, output logic exp_mis);
        logic [31:0] dout;
        logic        mis;
        int          lat;
        model(op, a, d, exp_dout, exp_mis);
        run_access(name, op, a, d, 0, dout, mis, lat);
        check({name, "_dout"}, dout, exp_dout);
        check({name, "_mis"}, {31'h0, mis}, {31'h0, exp_mis});
        check({name, "_lat"}, 32'(lat), exp_mis ? 32'd0 : 32'(LATENCY + 1));
    endtask

    initial begin
        logic [31:0] r;
        logic        m;
        logic [31:0] prev;
        logic        seen;
        int          lat;
        int          bad;
        logic [5:0]  ops [8];

        Clr = 1'b0;
        RAM_enable = 1'b0;
        RAM_OpCode = 6'h0;
        Address = 32'h0;
        DataIn = 32'h0;

        for (int i = 0; i < MEMSZ; i++) begin
            ref_mem[i] = 8'($urandom);
            if (i >= 8 && i <= 11) ref_mem[i] = 8'hFF;
            dut.u_ram.mem[i] <= ref_mem[i];
        end

        repeat (3) @(posedge Clk);
        #1;
        check("rst_mfc", {31'h0, MFC}, 32'h0);
        check("rst_dout", DataOut, 32'h0);
        check("rst_mis", {31'h0, Misaligned}, 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        Clr = 1'b1;
        @(posedge Clk); #1;

        vecs.push_back('{OP_LDSB, 32'h8,        32'h0,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{OP_LDUB, 32'h8,        32'h0,        32'h000000FF, 1'b0});
        vecs.push_back('{OP_ST,   32'h4,        32'h12345678, 32'h0,        1'b0});
        vecs.push_back('{OP_LD,   32'h4,        32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{OP_LDUH, 32'h6,        32'h0,        32'h00005678, 1'b0});
        vecs.push_back('{OP_LDSH, 32'h4,        32'h0,        32'h00001234, 1'b0});
        vecs.push_back('{OP_STB,  32'h9,        32'h000000AB, 32'h0,        1'b0});
        vecs.push_back('{OP_LD,   32'h8,        32'h0,        32'hFFABFFFF, 1'b0});
        vecs.push_back('{OP_LD,   32'h2,        32'h0,        32'h0,        1'b1});
        vecs.push_back('{OP_ST,   32'h5,        32'h0,        32'h0,        1'b1});
        vecs.push_back('{OP_LDUH, 32'h7,        32'h0,        32'h0,        1'b1});
        vecs.push_back('{OP_LD,   32'h4,        32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{6'b000111, 32'h4,      32'h0,        32'h0,        1'b0});
        vecs.push_back('{OP_LD,   32'h4,        32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{OP_ST,   32'h1FC,      32'h0A0B0C0D, 32'h0,        1'b0});
        vecs.push_back('{OP_LD,   32'h600005FC, 32'h0,        32'h0A0B0C0D, 1'b0});
        vecs.push_back('{OP_LDUB, 32'h1FF,      32'h0,        32'h0000000D, 1'b0});
        vecs.push_back('{OP_LDSH, 32'h1FE,      32'h0,        32'h00000C0D, 1'b0});
        vecs.push_back('{OP_STH,  32'h10,       32'h00008001, 32'h0,        1'b0});
        vecs.push_back('{OP_LDSH, 32'h10,       32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{OP_LDUH, 32'h10,       32'h0,        32'h00008001, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] dout;
            logic        mis;
            string       nm;
            nm = $sformatf("vec%0d", i);
            model(vecs[i].op, vecs[i].addr, vecs[i].data, r, m);
            run_access(nm, vecs[i].op, vecs[i].addr, vecs[i].data, 0, dout, mis, lat);
            check({nm, "_dout"}, dout, vecs[i].exp_dout);
            check({nm, "_mis"}, {31'h0, mis}, {31'h0, vecs[i].exp_mis});
            check({nm, "_lat"}, 32'(lat), vecs[i].exp_mis ? 32'd0 : 32'(LATENCY + 1));
        end
        check("mem_8_11", {dut.u_ram.mem[8], dut.u_ram.mem[9], dut.u_ram.mem[10], dut.u_ram.mem[11]},
              32'hFFABFFFF);

        // Abort by dropping RAM_enable in the first BUSY cycle.
        prev = DataOut;
        RAM_enable = 1'b1; RAM_OpCode = OP_ST; Address = 32'h0; DataIn = 32'hDEADBEEF;
        @(posedge Clk); #1;
        RAM_enable = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge Clk); #1; if (MFC) seen = 1'b1; end
        check("abort_mfc", {31'h0, seen}, 32'h0);
        check("abort_dout", DataOut, prev);
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        apply("abort_ld0", OP_LD, 32'h0, 32'h0, r, m);

        // Cancel by reset in the middle of BUSY.
        RAM_enable = 1'b1; RAM_OpCode = OP_ST; Address = 32'h0; DataIn = 32'hDEADBEEF;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        @(posedge Clk); #1;
        Clr = 1'b1;
        RAM_enable = 1'b0;
        check("rstmid_dout", DataOut, 32'h0);
        check("rstmid_state", 32'(dut.state_q), 32'(IDLE));
        seen = MFC;
        repeat (6) begin @(posedge Clk); #1; if (MFC) seen = 1'b1; end
        check("rstmid_mfc", {31'h0, seen}, 32'h0);
        apply("rstmid_ld0", OP_LD, 32'h0, 32'h0, r, m);

        // Hold RAM_enable five cycles beyond MFC.
        begin
            logic [31:0] dout;
            logic        mis;
            model(OP_LD, 32'h4, 32'h0, r, m);
            run_access("hold", OP_LD, 32'h4, 32'h0, 5, dout, mis, lat);
            check("hold_dout", dout, r);
            check("hold_state", 32'(dut.state_q), 32'(IDLE));
        end

        ops = '{OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_ST, OP_STB, OP_STH};
        for (int i = 0; i < 150; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31:9], 5'h1F, a[3:0]};
            apply($sformatf("rnd%0d", i), op, a, $urandom, r, m);
        end

        bad = 0;
        for (int i = 0; i < MEMSZ; i++) if (dut.u_ram.mem[i] !== ref_mem[i]) bad++;
        check("mem_final_bad_bytes", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of the storage array (2^ADDR_W bytes).
REQ-002 Parameter LATENCY, default 2, BUSY cycles between request capture and completion; legal range 1..15.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Clr  input  1  reset, synchronous, active-low.
REQ-005 RAM_enable  input  1  request valid, held high by initiator until MFC seen.
REQ-006 RAM_OpCode  input  6  SPARC op3 access code.
REQ-007 Address  input  32  byte address; bits above ADDR_W-1 ignored.
REQ-008 DataIn  input  32  store data, right-justified.
REQ-009 DataOut  output  32  load result, registered.
REQ-010 MFC  output  1  memory function complete, registered.
REQ-011 Misaligned  output  1  alignment fault flag, valid while MFC=1.

Function
REQ-012 Supported op3: LD 000000, LDUB 000001, LDUH 000010, LDSB 001001, LDSH 001010, ST 000100, STB 000101, STH 000110.
REQ-013 Byte order big-endian: word at A occupies A (bits 31:24) .. A+3 (bits 7:0).
REQ-014 States IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE with RAM_enable=1: latch opcode, address, data; clear counter; go BUSY, or DONE directly if misaligned.
REQ-016 Misaligned = halfword access with A[0]=1, or word access with A[1:0]!=00; no memory access, DataOut=0, Misaligned=1.
REQ-017 BUSY: counter increments each cycle; after LATENCY cycles in BUSY go DONE.
REQ-018 BUSY->DONE edge: store writes bytes per size from latched data; load registers DataOut.
REQ-019 LDUB/LDUH zero-extend; LDSB/LDSH sign-extend to 32 bits; LD full word.
REQ-020 Store completion sets DataOut=0.
REQ-021 Unrecognised opcode completes as no-op: no write, DataOut=0, Misaligned=0.
REQ-022 DONE: MFC=1, held while RAM_enable=1; RAM_enable=0 -> IDLE, MFC=0 next cycle.
REQ-023 RAM_enable=0 during BUSY aborts: no write, DataOut unchanged, return IDLE, MFC never asserted.
REQ-024 Input changes after capture have no effect on the in-flight access.
REQ-025 Address wraps modulo 2^ADDR_W; word at top-3 bytes uses the last four bytes, no wrap inside one access.
REQ-026 Back-to-back: new request accepted only from IDLE, so minimum one IDLE cycle between accesses.
REQ-027 Request to response latency = LATENCY+1 cycles from capture edge to MFC=1.

Reset
REQ-028 Clr=0 at a rising edge: state IDLE, MFC=0, DataOut=0, Misaligned=0, counter=0.
REQ-029 Reset mid-access cancels it; a pending store is not written.
REQ-030 Storage contents are not cleared by reset; testbench preload by hierarchical write is permitted.

Structure
REQ-031 Shared package holds op3 constants, state encoding, and size enum (BYTE, HALF, WORD).
REQ-032 One sub-module byte_ram: 2^ADDR_W x 8 array, four byte-lane write enables, combinational 4-byte big-endian read at a base address.
REQ-033 FSM, counter, decode, and extension logic live in mem_responder.

Verification
REQ-034 Preload bytes 8..11 = FF; LDSB @8 -> MFC after 3 cycles, DataOut=FFFFFFFF; LDUB @8 -> 000000FF.
REQ-035 ST 12345678 @4, then LD @4 -> 12345678; LDUH @6 -> 00005678; LDSH @4 -> 00001234.
REQ-036 STB AB @9 over FF bytes -> bytes 8..11 = FF AB FF FF; LD @8 -> FFABFFFF.
REQ-037 LD @2 -> MFC next cycle after capture, Misaligned=1, DataOut=0, memory unchanged.
REQ-038 ST DEADBEEF @0, drop RAM_enable in BUSY cycle 1 -> no MFC, word @0 unchanged; repeat with Clr=0 in BUSY -> same.
REQ-039 Hold RAM_enable 5 cycles after MFC -> MFC stays 1; release -> MFC=0 next cycle, state IDLE.
